// File: rtl/fp_pkg.sv
// Shared FP execution unit definitions: flag bit positions, FSM encoding,
// operand classes and special-value bit patterns.
package fp_pkg;

  localparam int NV_B = 4;
  localparam int DZ_B = 3;
  localparam int OF_B = 2;
  localparam int UF_B = 1;
  localparam int NX_B = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ITER,
    ST_NORM,
    ST_ROUND,
    ST_PACK,
    ST_DONE
  } fp_state_e;

  typedef enum logic [2:0] {
    CL_NORM,
    CL_SUB,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } fp_class_e;

  // Patterns are built 64 bits wide; callers slice to their operand width.
  function automatic logic [63:0] inf_pat(input int e, input int f);
    return ((64'd1 << e) - 64'd1) << f;
  endfunction

  function automatic logic [63:0] qnan_pat(input int e, input int f);
    return inf_pat(e, f) | (64'd1 << (f - 1));
  endfunction

endpackage

// File: rtl/fp_mul_iter_if.sv
// Start/done handshake and operand/result bus shared by the iterative FP units.
interface fp_mul_iter_if #(
  parameter int E = 8,
  parameter int F = 23
);
  logic         start;
  logic [E+F:0] a;
  logic [E+F:0] b;
  logic [E+F:0] y;
  logic [4:0]   flags;
  logic         done;

  modport master (output start, output a, output b, input y, input flags, input done);
  modport slave  (input start, input a, input b, output y, output flags, output done);
endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 operand into sign, class, effective exponent and
// significand with the hidden bit made explicit (0 for subnormals).
module fp_unpack
  import fp_pkg::*;
#(
  parameter int E = 8,
  parameter int F = 23
) (
  input  logic [E+F:0] x_i,
  output logic         sign_o,
  output fp_class_e    class_o,
  output logic [E-1:0] exp_eff_o,
  output logic [F:0]   sig_o
);

  logic [E-1:0] exp_w;
  logic [F-1:0] frac_w;
  logic         exp_ones;
  logic         exp_zero;
  logic         frac_zero;

  always_comb begin
    sign_o    = x_i[E+F];
    exp_w     = x_i[E+F-1:F];
    frac_w    = x_i[F-1:0];
    exp_ones  = &exp_w;
    exp_zero  = ~|exp_w;
    frac_zero = ~|frac_w;

    class_o = CL_NORM;
    if (exp_ones) class_o = frac_zero ? CL_INF : CL_NAN;
    else if (exp_zero) class_o = frac_zero ? CL_ZERO : CL_SUB;

    // Subnormals share the scale of exponent 1.
    exp_eff_o = exp_zero ? E'(1) : exp_w;
    sig_o     = {~exp_zero, frac_w};
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 multiplier: shift/add significand product, RNE rounding.
// IDLE wait | INIT decode | ITER shift-add | NORM align | ROUND rne | PACK encode | DONE publish
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int E = 8,
  parameter int F = 23
) (
  input logic          clk,
  input logic          rst,
  fp_mul_iter_if.slave bus
);

  localparam int W  = E + F + 1;
  localparam int PW = 2 * F + 2;
  localparam int XW = E + 2;
  localparam int CW = $clog2(F + 4);

  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] MAXE_X = XW'((1 << E) - 1);
  localparam logic [63:0]  INF64   = inf_pat(E, F);
  localparam logic [63:0]  QNAN64  = qnan_pat(E, F);
  localparam logic [W-2:0] INF_MAG = INF64[W-2:0];
  localparam logic [W-1:0] QNAN    = QNAN64[W-1:0];

  fp_state_e             state_q;
  logic [W-1:0]          a_q, b_q;
  logic [W-1:0]          res_q, y_q;
  logic [4:0]            flg_q, flags_q;
  logic                  done_q;
  logic                  sign_q, spec_q, sticky_q, tiny_q, nx_q;
  logic signed [XW-1:0]  ex_q;
  logic [F:0]            sig_a_q, mpl_q, mant_q;
  logic [PW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;

  logic                  sgn_a, sgn_b;
  fp_class_e             cls_a, cls_b;
  logic [E-1:0]          eeff_a, eeff_b;
  logic [F:0]            sig_a, sig_b;

  fp_unpack #(.E(E), .F(F)) u_unpack_a (
    .x_i       (a_q),
    .sign_o    (sgn_a),
    .class_o   (cls_a),
    .exp_eff_o (eeff_a),
    .sig_o     (sig_a)
  );

  fp_unpack #(.E(E), .F(F)) u_unpack_b (
    .x_i       (b_q),
    .sign_o    (sgn_b),
    .class_o   (cls_b),
    .exp_eff_o (eeff_b),
    .sig_o     (sig_b)
  );

  logic                  s_d, is_nan_d, is_inf_d, is_zero_d, spec_d;
  logic [W-1:0]          spec_res_d, pack_res_d;
  logic [4:0]            spec_flg_d, pack_flg_d;
  logic signed [XW-1:0]  ex_init_d, ex_inc_d, ex_dec_d;
  logic [F+1:0]          add_d, msum_d;
  logic [PW-1:0]         acc_iter_d;
  logic                  g_d, r_d, st_d, inc_d;

  always_comb begin
    s_d       = sgn_a ^ sgn_b;
    is_nan_d  = (cls_a == CL_NAN) || (cls_b == CL_NAN) ||
                ((cls_a == CL_INF) && (cls_b == CL_ZERO)) ||
                ((cls_a == CL_ZERO) && (cls_b == CL_INF));
    is_inf_d  = (cls_a == CL_INF) || (cls_b == CL_INF);
    is_zero_d = (cls_a == CL_ZERO) || (cls_b == CL_ZERO);
    spec_d    = is_nan_d || is_inf_d || is_zero_d;

    spec_res_d = {s_d, {(W-1){1'b0}}};
    spec_flg_d = '0;
    if (is_nan_d) begin
      spec_res_d       = QNAN;
      spec_flg_d[NV_B] = 1'b1;
    end else if (is_inf_d) begin
      spec_res_d = {s_d, INF_MAG};
    end

    ex_init_d = $signed({2'b00, eeff_a}) + $signed({2'b00, eeff_b}) - BIAS_X;
    ex_inc_d  = ex_q + ONE_X;
    ex_dec_d  = ex_q - ONE_X;

    // Partial product lands in the upper half; the carry becomes the new MSB.
    add_d      = {1'b0, acc_q[PW-1:F+1]} + {1'b0, sig_a_q};
    acc_iter_d = mpl_q[0] ? {add_d, acc_q[F:1]} : {1'b0, acc_q[PW-1:1]};

    g_d    = acc_q[F-1];
    r_d    = acc_q[F-2];
    st_d   = (|acc_q[F-3:0]) | sticky_q;
    inc_d  = g_d & (r_d | st_d | acc_q[F]);
    msum_d = {1'b0, acc_q[2*F:F]} + {{(F+1){1'b0}}, inc_d};

    pack_flg_d = '0;
    pack_res_d = {sign_q, INF_MAG};
    if (ex_q >= MAXE_X) begin
      pack_flg_d[OF_B] = 1'b1;
      pack_flg_d[NX_B] = 1'b1;
    end else begin
      pack_res_d       = {sign_q, (mant_q[F] ? ex_q[E-1:0] : {E{1'b0}}), mant_q[F-1:0]};
      pack_flg_d[UF_B] = tiny_q & nx_q;
      pack_flg_d[NX_B] = nx_q;
    end
    pack_flg_d[DZ_B] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      y_q      <= '0;
      flg_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      spec_q   <= 1'b0;
      sticky_q <= 1'b0;
      tiny_q   <= 1'b0;
      nx_q     <= 1'b0;
      ex_q     <= '0;
      sig_a_q  <= '0;
      mpl_q    <= '0;
      mant_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            done_q  <= 1'b0;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          sign_q <= s_d;
          spec_q <= spec_d;
          if (spec_d) begin
            // Special results ride through PACK untouched.
            res_q   <= spec_res_d;
            flg_q   <= spec_flg_d;
            state_q <= ST_PACK;
          end else begin
            ex_q     <= ex_init_d;
            sig_a_q  <= sig_a;
            mpl_q    <= sig_b;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CW'(F);
            state_q  <= ST_ITER;
          end
        end
        ST_ITER: begin
          acc_q <= acc_iter_d;
          mpl_q <= {1'b0, mpl_q[F:1]};
          if (cnt_q == '0) begin
            cnt_q   <= CW'(F + 3);
            state_q <= ST_NORM;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_NORM: begin
          if (acc_q[PW-1]) begin
            acc_q    <= {1'b0, acc_q[PW-1:1]};
            sticky_q <= sticky_q | acc_q[0];
            ex_q     <= ex_inc_d;
            if (ex_inc_d >= ONE_X) state_q <= ST_ROUND;
          end else if (!acc_q[2*F] && (ex_q > ONE_X)) begin
            acc_q <= {acc_q[PW-2:0], 1'b0};
            ex_q  <= ex_dec_d;
          end else if (ex_q < ONE_X) begin
            if (cnt_q == '0) begin
              // Everything is already below the round bit: fold into sticky.
              acc_q    <= '0;
              sticky_q <= sticky_q | (|acc_q);
              ex_q     <= ONE_X;
            end else begin
              acc_q    <= {1'b0, acc_q[PW-1:1]};
              sticky_q <= sticky_q | acc_q[0];
              ex_q     <= ex_inc_d;
              cnt_q    <= cnt_q - CW'(1);
            end
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          tiny_q <= (ex_q == ONE_X) && !acc_q[2*F];
          nx_q   <= g_d | r_d | st_d;
          if (msum_d[F+1]) begin
            mant_q <= {1'b1, {F{1'b0}}};
            ex_q   <= ex_inc_d;
          end else begin
            mant_q <= msum_d[F:0];
          end
          state_q <= ST_PACK;
        end
        ST_PACK: begin
          if (!spec_q) begin
            res_q <= pack_res_d;
            flg_q <= pack_flg_d;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          y_q     <= res_q;
          flags_q <= flg_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.y     = y_q;
  assign bus.flags = flags_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Vector table plus handshake corner sequences for fp_mul_iter (binary32).
module tb_fp_mul_iter;

  localparam int E = 8;
  localparam int F = 23;
  localparam int NV = 14;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_iter_if #(.E(E), .F(F)) bus ();
  fp_mul_iter #(.E(E), .F(F)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Drive one accepted start; the edge after the negedge is cycle 0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] y,
                        input logic [4:0] fl, input int lat, input bit push, input string tag);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (push) sb.push_back('{y: y, fl: fl, lat: lat});
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // k0 = edges already elapsed since the accepting edge.
  task automatic finish_op(input int k0, input string tag);
    int   lat;
    exp_t e;
    lat = -1;
    for (int k = k0 + 1; k <= k0 + 200; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: done never rose, required at cycle %0d", tag, e.lat);
    end else begin
      chk({tag, "_y"}, bus.y, e.y);
      chk({tag, "_flags"}, 32'(bus.flags), 32'(e.fl));
      if (e.lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 29};
    vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 3};
    vecs[2]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 3};
    vecs[3]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'b00101, 29};
    vecs[4]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 29};
    vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00400000, 5'b00000, 30};
    vecs[6]  = '{32'h00000001, 32'h3F000000, 32'h00000000, 5'b00011, 30};
    vecs[7]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 29};
    vecs[8]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000, 29};
    vecs[9]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000, 29};
    vecs[10] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 3};
    vecs[11] = '{32'h00000000, 32'hC0400000, 32'h80000000, 5'b00000, 3};
    vecs[12] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 5'b00000, 3};
    vecs[13] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000, 3};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_y", bus.y, 32'd0);
    chk("reset_flags", 32'(bus.flags), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].fl, vecs[i].lat, 1'b1, $sformatf("vec%0d", i));
      finish_op(0, $sformatf("vec%0d", i));
    end

    // A start held high while the multiply is iterating must not restart it.
    launch(32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 29, 1'b1, "hold");
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 32'h40000000;
    bus.b     = 32'h40000000;
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_op(12, "hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_stay_done", 32'(bus.done), 32'd1);
    chk("hold_stay_y", bus.y, 32'h3F800000);

    // Back-to-back: start held continuously, second op accepted at cycle 30.
    @(negedge clk);
    bus.a     = 32'h3FC00000;
    bus.b     = 32'h40000000;
    bus.start = 1'b1;
    sb.push_back('{y: 32'h40400000, fl: 5'b00000, lat: 29});
    @(posedge clk);
    #1;
    bus.a = 32'hC0000000;
    bus.b = 32'h40400000;
    sb.push_back('{y: 32'hC0C00000, fl: 5'b00000, lat: 59});
    finish_op(0, "b2b_first");
    @(posedge clk);
    #1;
    chk("b2b_done_clr", 32'(bus.done), 32'd0);
    chk("b2b_y_hold", bus.y, 32'h40400000);
    bus.start = 1'b0;
    finish_op(30, "b2b_second");

    // Reset at cycle 10 aborts the operation without writing a result.
    launch(32'h3FC00000, 32'h40000000, 32'h0, 5'b0, 0, 1'b0, "abort");
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_y", bus.y, 32'd0);
    chk("abort_flags", 32'(bus.flags), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_late_done", 32'(bus.done), 32'd0);
    chk("abort_late_y", bus.y, 32'd0);

    launch(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 29, 1'b1, "post_rst");
    finish_op(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
